// File: rtl/hub75_scheduler_if.sv
// hub75_scheduler_if
// Bundles the run-control inputs and driver-order/fetch-address outputs of the
// HUB75 row/bit-plane scheduler.
//   master : the scheduler (drives out_*, receives in_*)
//   slave  : the environment, i.e. driver + fetch logic (drives in_*, receives out_*)
// Parameters COLS/PLANES must equal those of the scheduler instance.
interface hub75_scheduler_if #(
    parameter int COLS   = 64,
    parameter int PLANES = 4
);
    localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic          in_ENABLE;
    logic          in_BRIGHT_DIM;
    logic          in_WAITING;
    logic          in_ITER;
    logic          out_INIT;
    logic          out_SHOW;
    logic [4:0]    out_ROW;
    logic          out_BRIGHT_DIM;
    logic [4:0]    out_FETCH_ROW;
    logic [PW-1:0] out_PLANE;
    logic [CW-1:0] out_COL;
    logic          out_FRAME_DONE;
    logic          out_BUSY;

    modport master (
        input  in_ENABLE, in_BRIGHT_DIM, in_WAITING, in_ITER,
        output out_INIT, out_SHOW, out_ROW, out_BRIGHT_DIM, out_FETCH_ROW,
               out_PLANE, out_COL, out_FRAME_DONE, out_BUSY
    );

    modport slave (
        output in_ENABLE, in_BRIGHT_DIM, in_WAITING, in_ITER,
        input  out_INIT, out_SHOW, out_ROW, out_BRIGHT_DIM, out_FETCH_ROW,
               out_PLANE, out_COL, out_FRAME_DONE, out_BUSY
    );
endinterface

// File: rtl/hub75_scheduler.sv
// hub75_scheduler
// Row / bit-plane scheduler for the HUB75 panel driver. Chooses the next slot
// (fetch row, plane), orders the driver to shift it (out_INIT) and to latch it
// (out_SHOW), and times each displayed plane with binary-code modulation
// (window = BASE_TICKS << plane). The next slot is shifted while the current
// one is displayed.
// Ports:
//   clk  : system clock, posedge
//   rst  : asynchronous active-low reset
//   bus  : hub75_scheduler_if.master (run control in, driver orders and
//          fetch addresses out); every output is a flop.
module hub75_scheduler #(
    parameter int ROWS       = 32,
    parameter int COLS       = 64,
    parameter int PLANES     = 4,
    parameter int BASE_TICKS = 64
) (
    input  logic              clk,
    input  logic              rst,
    hub75_scheduler_if.master bus
);
    localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TW = $clog2(BASE_TICKS << (PLANES - 1)) + 1;

    localparam logic [4:0]    ROW_LAST   = 5'(ROWS - 1);
    localparam logic [PW-1:0] PLANE_LAST = PW'(PLANES - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [TW-1:0] BASE_WIN   = TW'(BASE_TICKS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_HOLD   = 3'd4,
        ST_LATCH  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          settle_q, settle_d;

    logic          init_q, init_d;
    logic          show_q, show_d;
    logic [4:0]    row_q, row_d;
    logic          bright_q, bright_d;
    logic [4:0]    frow_q, frow_d;
    logic [PW-1:0] plane_q, plane_d;
    logic [CW-1:0] col_q, col_d;
    logic          frame_done_q, frame_done_d;
    logic          busy_q, busy_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          disp_valid_q, disp_valid_d;
    logic          latch_go_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            settle_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d  = state_q;
        settle_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_ENABLE) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // settle_q marks the second SETTLE cycle
                settle_d = 1'b1;
                if (settle_q) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_LOAD: begin
                // in_WAITING deliberately not looked at here: it may still be
                // high from the previous shift
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bus.in_WAITING) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (!disp_valid_q || (timer_q == '0)) begin
                    state_d = ST_LATCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_LATCH: begin
                // an enable drop only takes effect at a slot boundary
                if (bus.in_ENABLE) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: next values of all output flops, so each flop lines up
    // with the state it belongs to
    always_comb begin
        latch_go_s   = (state_q == ST_HOLD) && (state_d == ST_LATCH);
        init_d       = (state_d == ST_LOAD);
        show_d       = (state_d == ST_LATCH);
        busy_d       = (state_d != ST_IDLE);
        bright_d     = bus.in_BRIGHT_DIM;
        // the pointer is already past the wrap slot while in LATCH
        frame_done_d = (state_q == ST_LATCH) && (frow_q == 5'd0) && (plane_q == '0);

        if (state_d == ST_LOAD) begin
            col_d = '0;
        end else if ((state_q == ST_SHIFT) && bus.in_ITER) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
            end else begin
                col_d = col_q + CW'(1);
            end
        end else begin
            col_d = col_q;
        end

        if (latch_go_s) begin
            row_d        = frow_q;
            timer_d      = BASE_WIN << plane_q;
            disp_valid_d = 1'b1;
            if (plane_q == PLANE_LAST) begin
                plane_d = '0;
                if (frow_q == ROW_LAST) begin
                    frow_d = 5'd0;
                end else begin
                    frow_d = frow_q + 5'd1;
                end
            end else begin
                plane_d = plane_q + PW'(1);
                frow_d  = frow_q;
            end
        end else begin
            row_d        = row_q;
            disp_valid_d = disp_valid_q;
            plane_d      = plane_q;
            frow_d       = frow_q;
            if (timer_q != '0) begin
                timer_d = timer_q - TW'(1);
            end else begin
                timer_d = timer_q;
            end
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_q       <= 1'b0;
            show_q       <= 1'b0;
            row_q        <= 5'd0;
            bright_q     <= 1'b0;
            frow_q       <= 5'd0;
            plane_q      <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            timer_q      <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            init_q       <= init_d;
            show_q       <= show_d;
            row_q        <= row_d;
            bright_q     <= bright_d;
            frow_q       <= frow_d;
            plane_q      <= plane_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            timer_q      <= timer_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    assign bus.out_INIT       = init_q;
    assign bus.out_SHOW       = show_q;
    assign bus.out_ROW        = row_q;
    assign bus.out_BRIGHT_DIM = bright_q;
    assign bus.out_FETCH_ROW  = frow_q;
    assign bus.out_PLANE      = plane_q;
    assign bus.out_COL        = col_q;
    assign bus.out_FRAME_DONE = frame_done_q;
    assign bus.out_BUSY       = busy_q;
endmodule
